// File: rtl/hv_classifier.sv
// Hamming-distance classifier: compares a query hypervector against snapshotted non-seizure and
// seizure class vectors, CHUNK bits per cycle, and reports both distances plus the closer label.
module hv_classifier #(
  parameter int DIMENSIONS = 10000,
  parameter int CHUNK      = 100,
  localparam int DIST_W    = $clog2(DIMENSIONS + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DIMENSIONS-1:0] query_hv,
  input  logic                  q_valid,
  output logic                  q_ready,
  input  logic [DIMENSIONS-1:0] ns_hv,
  input  logic [DIMENSIONS-1:0] s_hv,
  output logic                  pred_valid,
  output logic                  pred_label,
  output logic [DIST_W-1:0]     ns_dist,
  output logic [DIST_W-1:0]     s_dist
);

  localparam int NUM_CHUNKS = DIMENSIONS / CHUNK;
  localparam int K_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if (DIMENSIONS % CHUNK != 0) begin : g_bad_chunk
    $error("hv_classifier: DIMENSIONS must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [DIST_W-1:0]     acc_ns_q, acc_ns_d;
  logic [DIST_W-1:0]     acc_s_q, acc_s_d;
  logic [DIMENSIONS-1:0] q_snap_q, q_snap_d;
  logic [DIMENSIONS-1:0] ns_snap_q, ns_snap_d;
  logic [DIMENSIONS-1:0] s_snap_q, s_snap_d;
  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_label_q, pred_label_d;
  logic [DIST_W-1:0]     ns_dist_q, ns_dist_d;
  logic [DIST_W-1:0]     s_dist_q, s_dist_d;

  logic [CHUNK-1:0]      diff_ns, diff_s;
  logic [DIST_W-1:0]     cnt_ns, cnt_s;

  // Snapshots shift right each COMPUTE cycle, so the current chunk always sits in the low bits.
  always_comb begin
    diff_ns = q_snap_q[CHUNK-1:0] ^ ns_snap_q[CHUNK-1:0];
    diff_s  = q_snap_q[CHUNK-1:0] ^ s_snap_q[CHUNK-1:0];
    cnt_ns  = '0;
    cnt_s   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt_ns = cnt_ns + DIST_W'(diff_ns[i]);
      cnt_s  = cnt_s + DIST_W'(diff_s[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    acc_ns_d     = acc_ns_q;
    acc_s_d      = acc_s_q;
    q_snap_d     = q_snap_q;
    ns_snap_d    = ns_snap_q;
    s_snap_d     = s_snap_q;
    pred_valid_d = 1'b0;
    pred_label_d = pred_label_q;
    ns_dist_d    = ns_dist_q;
    s_dist_d     = s_dist_q;
    unique case (state_q)
      StIdle: begin
        if (q_valid) begin
          q_snap_d  = query_hv;
          ns_snap_d = ns_hv;
          s_snap_d  = s_hv;
          acc_ns_d  = '0;
          acc_s_d   = '0;
          k_d       = '0;
          state_d   = StCompute;
        end
      end
      StCompute: begin
        acc_ns_d  = acc_ns_q + cnt_ns;
        acc_s_d   = acc_s_q + cnt_s;
        q_snap_d  = q_snap_q >> CHUNK;
        ns_snap_d = ns_snap_q >> CHUNK;
        s_snap_d  = s_snap_q >> CHUNK;
        k_d       = k_q + K_W'(1);
        if (k_q == K_W'(NUM_CHUNKS - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        ns_dist_d    = acc_ns_q;
        s_dist_d     = acc_s_q;
        pred_label_d = (acc_s_q < acc_ns_q);  // ties resolve to non-seizure
        pred_valid_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q      <= StIdle;
      k_q          <= '0;
      acc_ns_q     <= '0;
      acc_s_q      <= '0;
      q_snap_q     <= '0;
      ns_snap_q    <= '0;
      s_snap_q     <= '0;
      pred_valid_q <= 1'b0;
      pred_label_q <= 1'b0;
      ns_dist_q    <= '0;
      s_dist_q     <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      acc_ns_q     <= acc_ns_d;
      acc_s_q      <= acc_s_d;
      q_snap_q     <= q_snap_d;
      ns_snap_q    <= ns_snap_d;
      s_snap_q     <= s_snap_d;
      pred_valid_q <= pred_valid_d;
      pred_label_q <= pred_label_d;
      ns_dist_q    <= ns_dist_d;
      s_dist_q     <= s_dist_d;
    end
  end

  assign q_ready    = (state_q == StIdle) && !nrst;
  assign pred_valid = pred_valid_q;
  assign pred_label = pred_label_q;
  assign ns_dist    = ns_dist_q;
  assign s_dist     = s_dist_q;

endmodule

// File: tb/tb_hv_classifier.sv
// Scoreboard bench for hv_classifier: a 5-bit/1-bit-chunk instance with random traffic and
// directed corner cases, plus a full-size 10000/100 instance.
module tb_hv_classifier;

  localparam int DS   = 5;
  localparam int CS   = 1;
  localparam int NC_S = DS / CS;
  localparam int WS   = $clog2(DS + 1);
  localparam int DB   = 10000;
  localparam int CB   = 100;
  localparam int NC_B = DB / CB;
  localparam int WB   = $clog2(DB + 1);

  typedef struct {
    int ns_d;
    int s_d;
    int label;
    int due;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sq[$];
  exp_t bq[$];
  int   busy_s = 0;
  int   busy_b = 0;

  // Small instance
  logic          nrst_s = 1'b1;
  logic [DS-1:0] query_s = '0, ns_s = '0, s_s = '0;
  logic          q_valid_s = 1'b0;
  logic          q_ready_s, pv_s, pl_s;
  logic [WS-1:0] nsd_s, sd_s;

  // Full-size instance
  logic          nrst_b = 1'b1;
  logic [DB-1:0] query_b = '0, ns_b = '0, s_b = '0;
  logic          q_valid_b = 1'b0;
  logic          q_ready_b, pv_b, pl_b;
  logic [WB-1:0] nsd_b, sd_b;

  hv_classifier #(.DIMENSIONS(DS), .CHUNK(CS)) u_small (
    .clk(clk), .nrst(nrst_s), .query_hv(query_s), .q_valid(q_valid_s), .q_ready(q_ready_s),
    .ns_hv(ns_s), .s_hv(s_s), .pred_valid(pv_s), .pred_label(pl_s), .ns_dist(nsd_s),
    .s_dist(sd_s)
  );

  hv_classifier #(.DIMENSIONS(DB), .CHUNK(CB)) u_big (
    .clk(clk), .nrst(nrst_b), .query_hv(query_b), .q_valid(q_valid_b), .q_ready(q_ready_b),
    .ns_hv(ns_b), .s_hv(s_b), .pred_valid(pv_b), .pred_label(pl_b), .ns_dist(nsd_b),
    .s_dist(sd_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic logic [DB-1:0] rnd_big();
    logic [DB-1:0] r;
    for (int i = 0; i < DB; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  // Drive one cycle on the small instance; acceptance is decided by the bench's own busy model.
  task automatic drv(input bit v, input logic [DS-1:0] q, input logic [DS-1:0] ns,
                     input logic [DS-1:0] s);
    logic exp_rdy;
    exp_t e;
    @(negedge clk);
    exp_rdy = !nrst_s && (cyc > busy_s);
    chk("small q_ready", int'(q_ready_s), int'(exp_rdy));
    q_valid_s = v;
    query_s   = q;
    ns_s      = ns;
    s_s       = s;
    if (v && exp_rdy) begin
      e.ns_d  = $countones(q ^ ns);
      e.s_d   = $countones(q ^ s);
      e.label = (e.s_d < e.ns_d) ? 1 : 0;
      e.due   = cyc + 1 + NC_S + 1;
      sq.push_back(e);
      busy_s  = cyc + 1 + NC_S;
    end
  endtask

  task automatic drv_b(input bit v, input logic [DB-1:0] q, input logic [DB-1:0] ns,
                       input logic [DB-1:0] s);
    logic exp_rdy;
    exp_t e;
    @(negedge clk);
    exp_rdy = !nrst_b && (cyc > busy_b);
    chk("big q_ready", int'(q_ready_b), int'(exp_rdy));
    q_valid_b = v;
    query_b   = q;
    ns_b      = ns;
    s_b       = s;
    if (v && exp_rdy) begin
      e.ns_d  = $countones(q ^ ns);
      e.s_d   = $countones(q ^ s);
      e.label = (e.s_d < e.ns_d) ? 1 : 0;
      e.due   = cyc + 1 + NC_B + 1;
      bq.push_back(e);
      busy_b  = cyc + 1 + NC_B;
    end
  endtask

  // Hold reset for n cycles with random inputs and q_valid high; everything must read zero.
  task automatic reset_small(input int n);
    @(negedge clk);
    nrst_s    = 1'b1;
    q_valid_s = 1'b1;
    sq.delete();
    busy_s    = 0;
    repeat (n) begin
      @(negedge clk);
      chk("rst q_ready", int'(q_ready_s), 0);
      chk("rst pred_valid", int'(pv_s), 0);
      chk("rst pred_label", int'(pl_s), 0);
      chk("rst ns_dist", int'(nsd_s), 0);
      chk("rst s_dist", int'(sd_s), 0);
      query_s = DS'($urandom);
      ns_s    = DS'($urandom);
      s_s     = DS'($urandom);
    end
    nrst_s    = 1'b0;
    q_valid_s = 1'b0;
  endtask

  initial begin : mon_small
    exp_t e;
    forever begin
      @(negedge clk);
      if (pv_s) begin
        if (sq.size() == 0) begin
          chk("small spurious pred_valid", int'(pv_s), 0);
        end else begin
          e = sq.pop_front();
          chk("small ns_dist", int'(nsd_s), e.ns_d);
          chk("small s_dist", int'(sd_s), e.s_d);
          chk("small pred_label", int'(pl_s), e.label);
          chk("small latency", cyc, e.due);
        end
      end else if (sq.size() != 0 && cyc > sq[0].due) begin
        chk("small pred_valid timeout", int'(pv_s), 1);
        void'(sq.pop_front());
      end
    end
  end

  initial begin : mon_big
    exp_t e;
    forever begin
      @(negedge clk);
      if (pv_b) begin
        if (bq.size() == 0) begin
          chk("big spurious pred_valid", int'(pv_b), 0);
        end else begin
          e = bq.pop_front();
          chk("big ns_dist", int'(nsd_b), e.ns_d);
          chk("big s_dist", int'(sd_b), e.s_d);
          chk("big pred_label", int'(pl_b), e.label);
          chk("big latency", cyc, e.due);
        end
      end else if (bq.size() != 0 && cyc > bq[0].due) begin
        chk("big pred_valid timeout", int'(pv_b), 1);
        void'(bq.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [DB-1:0] bq_v, bns_v, bs_v;
    reset_small(3);
    drv(0, '0, '0, '0);

    // Clear seizure, clear non-seizure, and tie cases
    drv(1, 5'b11111, 5'b00000, 5'b11111);
    repeat (NC_S + 2) drv(0, '0, '0, '0);
    drv(1, 5'b10001, 5'b10001, 5'b11111);
    repeat (NC_S + 2) drv(0, '0, '0, '0);
    drv(1, 5'b00000, 5'b00011, 5'b11000);
    repeat (NC_S + 2) drv(0, '0, '0, '0);

    // Snapshot and backpressure: class vector changes mid-computation, q_valid held high
    drv(1, 5'b11111, 5'b00000, 5'b11111);
    repeat (NC_S + 2) drv(1, 5'b10001, 5'b10001, 5'b00000);
    drv(0, '0, '0, '0);
    repeat (NC_S + 2) drv(0, '0, '0, '0);

    // Reset during the third COMPUTE cycle aborts the result
    drv(1, 5'b11111, 5'b00000, 5'b11111);
    drv(0, '0, '0, '0);
    drv(0, '0, '0, '0);
    reset_small(1);
    repeat (NC_S + 3) drv(0, '0, '0, '0);

    for (int i = 0; i < 120; i++) begin
      drv(($urandom % 4) != 0, DS'($urandom), DS'($urandom), DS'($urandom));
    end
    repeat (NC_S + 3) drv(0, '0, '0, '0);

    // Full-size instance
    @(negedge clk);
    nrst_b = 1'b0;
    bq_v = rnd_big();
    drv_b(1, bq_v, ~bq_v, bq_v);
    repeat (NC_B + 2) drv_b(0, rnd_big(), '0, '0);
    bq_v  = rnd_big();
    bns_v = rnd_big();
    bs_v  = rnd_big();
    drv_b(1, bq_v, bns_v, bs_v);
    repeat (NC_B + 3) drv_b(1, ~bq_v, bs_v, bns_v);
    drv_b(0, '0, '0, '0);
    repeat (NC_B + 3) drv_b(0, '0, '0, '0);

    chk("small scoreboard drained", sq.size(), 0);
    chk("big scoreboard drained", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
